// File: rtl/proximity_alarm_ctrl.sv
// Distance-zone alarm: classifies filtered distance into SAFE/WARN/NEAR/CRIT and drives LED and buzzer tones.
// Define PROX_ALARM_HYST_EN to enable exit hysteresis; otherwise HYST is ignored.
module proximity_alarm_ctrl #(
    parameter int DW             = 13,
    parameter int TH_WARN        = 200,
    parameter int TH_NEAR        = 50,
    parameter int TH_CRIT        = 30,
    parameter int HYST           = 10,
    parameter int TONE_NEAR_HALF = 25000,
    parameter int TONE_CRIT_HALF = 12500,
    parameter int GATE_HALF      = 5_000_000
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    input  logic [DW-1:0] data_in,
    input  logic          data_valid,
    input  logic          mute,
    output logic          beep_out,
    output logic          led_out,
    output logic [1:0]    zone
);

    typedef enum logic [1:0] {
        Z_SAFE = 2'd0,
        Z_WARN = 2'd1,
        Z_NEAR = 2'd2,
        Z_CRIT = 2'd3
    } zone_e;

`ifdef PROX_ALARM_HYST_EN
    localparam int HYST_EFF = HYST;
`else
    // Zero hysteresis makes the exit rule collapse onto the plain entry rule.
    localparam int HYST_EFF = HYST * 0;
`endif

    localparam int TONE_MAX = (TONE_NEAR_HALF > TONE_CRIT_HALF) ? TONE_NEAR_HALF : TONE_CRIT_HALF;
    localparam int TW       = $clog2(TONE_MAX);
    localparam int GW       = $clog2(GATE_HALF);

    localparam logic [DW:0] TH_C   = (DW+1)'(TH_CRIT);
    localparam logic [DW:0] TH_N   = (DW+1)'(TH_NEAR);
    localparam logic [DW:0] TH_W   = (DW+1)'(TH_WARN);
    localparam logic [DW:0] TH_C_X = (DW+1)'(TH_CRIT + HYST_EFF);
    localparam logic [DW:0] TH_N_X = (DW+1)'(TH_NEAR + HYST_EFF);
    localparam logic [DW:0] TH_W_X = (DW+1)'(TH_WARN + HYST_EFF);

    localparam logic [TW-1:0] TONE_NEAR_LAST = TW'(TONE_NEAR_HALF - 1);
    localparam logic [TW-1:0] TONE_CRIT_LAST = TW'(TONE_CRIT_HALF - 1);
    localparam logic [GW-1:0] GATE_LAST      = GW'(GATE_HALF - 1);

    function automatic zone_e classify(input logic [DW:0] d, input logic [DW:0] tc,
                                       input logic [DW:0] tn, input logic [DW:0] tw);
        if (d <= tc)      return Z_CRIT;
        else if (d <= tn) return Z_NEAR;
        else if (d <= tw) return Z_WARN;
        else              return Z_SAFE;
    endfunction

    zone_e          zone_q, zone_d;
    logic           led_q, beep_q;
    logic [TW-1:0]  tone_cnt_q;
    logic           tone_ph_q;
    logic [GW-1:0]  gate_cnt_q;
    logic           gate_off_q;

    logic [DW:0]    din_x;
    logic [DW:0]    exit_lim;
    zone_e          entry;
    logic           restart;
    logic           tone_bit;
    logic [TW-1:0]  tone_last;

    always_comb begin
        din_x    = {1'b0, data_in};
        entry    = classify(din_x, TH_C, TH_N, TH_W);
        zone_d   = zone_q;
        exit_lim = '1;
        case (zone_q)
            Z_CRIT:  exit_lim = TH_C_X;
            Z_NEAR:  exit_lim = TH_N_X;
            Z_WARN:  exit_lim = TH_W_X;
            default: exit_lim = '1;
        endcase
        if (data_valid) begin
            if (entry > zone_q)
                zone_d = entry;
            else if (din_x > exit_lim)
                zone_d = classify(din_x, TH_C_X, TH_N_X, TH_W_X);
        end
        restart = (zone_d != zone_q);

        tone_last = (zone_q == Z_NEAR) ? TONE_NEAR_LAST : TONE_CRIT_LAST;
        case (zone_q)
            Z_NEAR:  tone_bit = tone_ph_q & ~gate_off_q;
            Z_CRIT:  tone_bit = tone_ph_q;
            default: tone_bit = 1'b0;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            zone_q     <= Z_SAFE;
            led_q      <= 1'b0;
            beep_q     <= 1'b0;
            tone_cnt_q <= '0;
            tone_ph_q  <= 1'b0;
            gate_cnt_q <= '0;
            gate_off_q <= 1'b0;
        end else begin
            zone_q <= zone_d;
            led_q  <= (zone_q != Z_SAFE);
            beep_q <= tone_bit & ~mute;
            // Tone and cadence restart together with the newly registered zone.
            if (restart) begin
                tone_cnt_q <= '0;
                tone_ph_q  <= 1'b0;
                gate_cnt_q <= '0;
                gate_off_q <= 1'b0;
            end else begin
                if (tone_cnt_q == tone_last) begin
                    tone_cnt_q <= '0;
                    tone_ph_q  <= ~tone_ph_q;
                end else begin
                    tone_cnt_q <= tone_cnt_q + TW'(1);
                end
                if (gate_cnt_q == GATE_LAST) begin
                    gate_cnt_q <= '0;
                    gate_off_q <= ~gate_off_q;
                end else begin
                    gate_cnt_q <= gate_cnt_q + GW'(1);
                end
            end
        end
    end

    assign zone     = zone_q;
    assign led_out  = led_q;
    assign beep_out = beep_q;

endmodule

// File: tb/tb_proximity_alarm_ctrl.sv
// Randomized self-checking bench for proximity_alarm_ctrl against a cycle-count reference model.
module tb_proximity_alarm_ctrl;
    localparam int DW  = 13;
    localparam int TW_ = 200;
    localparam int TN_ = 50;
    localparam int TC_ = 30;
    localparam int TNH = 4;
    localparam int TCH = 2;
    localparam int GH  = 20;
`ifdef PROX_ALARM_HYST_EN
    localparam int H = 10;
`else
    localparam int H = 0;
`endif

    logic          sys_clk = 1'b0;
    logic          sys_rst = 1'b1;
    logic [DW-1:0] data_in = '0;
    logic          data_valid = 1'b0;
    logic          mute = 1'b0;
    logic          beep_out, led_out;
    logic [1:0]    zone;

    proximity_alarm_ctrl #(
        .DW(DW), .TH_WARN(TW_), .TH_NEAR(TN_), .TH_CRIT(TC_), .HYST(10),
        .TONE_NEAR_HALF(TNH), .TONE_CRIT_HALF(TCH), .GATE_HALF(GH)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .data_in(data_in), .data_valid(data_valid),
        .mute(mute), .beep_out(beep_out), .led_out(led_out), .zone(zone)
    );

    always #5 sys_clk = ~sys_clk;

    int   errors = 0;
    int   checks = 0;
    int   th[4] = '{0, TW_, TN_, TC_};
    int   m_zone = 0;
    int   m_t = 0;
    logic m_led = 1'b0;
    logic m_beep = 1'b0;
    logic rr, rv, mute_s;
    int   rd;

    function automatic int entry_zone(int d, int h);
        int k = 0;
        for (int z = 1; z < 4; z++)
            if (d <= th[z] + h) k = z;
        return k;
    endfunction

    function automatic int next_zone(int cur, int d);
        int e = entry_zone(d, 0);
        if (e > cur) return e;
        if (cur != 0 && d > th[cur] + H) return entry_zone(d, H);
        return cur;
    endfunction

    function automatic logic tone_ref(int z, int t);
        if (z == 2) return ((t / TNH) % 2 == 1) && ((t / GH) % 2 == 0);
        if (z == 3) return ((t / TCH) % 2 == 1);
        return 1'b0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    task automatic tick(input logic r, input logic v, input int d, input logic m);
        int   nz;
        logic nb, nl;
        sys_rst    = r;
        data_valid = v;
        data_in    = DW'(d);
        mute       = m;
        @(posedge sys_clk);
        #1;
        if (r) begin
            m_zone = 0; m_t = 0; m_led = 1'b0; m_beep = 1'b0;
        end else begin
            nl = (m_zone != 0);
            nb = !m && tone_ref(m_zone, m_t);
            nz = v ? next_zone(m_zone, d) : m_zone;
            if (nz != m_zone) m_t = 0;
            else m_t++;
            m_zone = nz; m_led = nl; m_beep = nb;
        end
        check("zone", 32'(zone), 32'(m_zone));
        check("led", 32'(led_out), 32'(m_led));
        check("beep", 32'(beep_out), 32'(m_beep));
    endtask

    task automatic idle(input int n, input logic m);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 0, m);
    endtask

    initial begin
        repeat (3) tick(1'b1, 1'b1, 20, 1'b0);
        tick(1'b0, 1'b1, 250, 1'b0);
        idle(100, 1'b0);
        tick(1'b0, 1'b1, 150, 1'b0);
        idle(5, 1'b0);
        tick(1'b0, 1'b1, 40, 1'b0);
        idle(90, 1'b0);
        tick(1'b0, 1'b1, 20, 1'b0);
        idle(11, 1'b0);
        idle(6, 1'b1);
        idle(9, 1'b0);
        tick(1'b0, 1'b1, 35, 1'b0);
        idle(6, 1'b0);
        tick(1'b0, 1'b1, 41, 1'b0);
        idle(6, 1'b0);
        tick(1'b0, 1'b1, 20, 1'b0);
        idle(4, 1'b0);
        tick(1'b0, 1'b1, 255, 1'b0);
        idle(4, 1'b0);
        tick(1'b0, 1'b1, 40, 1'b0);
        idle(27, 1'b0);
        tick(1'b1, 1'b1, 20, 1'b0);
        idle(10, 1'b0);
        tick(1'b0, 1'b1, 8191, 1'b0);
        idle(3, 1'b0);

        mute_s = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            rr = ($urandom_range(0, 299) == 0);
            rv = ($urandom_range(0, 11) == 0);
            case ($urandom_range(0, 3))
                0:       rd = int'($urandom_range(0, 8191));
                1:       rd = int'($urandom_range(0, 60));
                default: rd = th[$urandom_range(1, 3)] + int'($urandom_range(0, 24)) - 12;
            endcase
            if ($urandom_range(0, 19) == 0) mute_s = ~mute_s;
            tick(rr, rv, rd, mute_s);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
